// File: rtl/decoder_onehot_seq_if.sv
// Bus bundle for decoder_onehot_seq: mode/address inputs and decoded outputs.
// The master drives the request side; the decoder is the slave.
interface decoder_onehot_seq_if #(
  parameter int ADDR_W = 5,
  parameter int OUT_N  = 32
);
  logic              iEna;
  logic [1:0]        iMode;
  logic [ADDR_W-1:0] iData;
  logic [OUT_N-1:0]  oData;
  logic [ADDR_W-1:0] oIdx;
  logic              oValid;
  logic              oErr;

  modport master (
    output iEna, iMode, iData,
    input  oData, oIdx, oValid, oErr
  );

  modport slave (
    input  iEna, iMode, iData,
    output oData, oIdx, oValid, oErr
  );
endinterface

// File: rtl/decoder_onehot_seq.sv
// Registered one-hot decoder with latch, strobe, auto-scan and clear modes.
// Optional build macro SCAN_BIDIR_EN: when defined, SCAN walks ping-pong
// (0..OUT_N-1..0) instead of wrapping upward; when undefined no direction
// register exists.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | cleared; oData all-zero
// ST_LATCH  | decoding iData every enabled edge, result held
// ST_STROBE | alternating one-cycle decode pulse / zero cycle
// ST_SCAN   | walking one-hot, one step every SCAN_DIV enabled cycles
module decoder_onehot_seq #(
  parameter int ADDR_W   = 5,
  parameter int OUT_N    = 32,
  parameter int SCAN_DIV = 4,
  parameter int DIV_W    = 16
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  decoder_onehot_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_STROBE = 2'd2,
    ST_SCAN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_N - 1);
  localparam logic [DIV_W-1:0]  DIV_TC   = DIV_W'(SCAN_DIV - 1);

  state_t             state_q, state_d;
  logic [OUT_N-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  // High in the cycle after a strobe pulse was issued, so the next edge zeroes.
  logic               strobe_hi_q, strobe_hi_d;
  logic               in_range;
  logic [ADDR_W-1:0]  scan_nxt;
`ifdef SCAN_BIDIR_EN
  // 0 = counting up, 1 = counting down.
  logic               dir_q, dir_d;
  logic               dir_nxt;
`endif

  function automatic logic [OUT_N-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [OUT_N-1:0] res;
    for (int i = 0; i < OUT_N; i++) begin
      res[i] = (32'(idx) == 32'(i));
    end
    return res;
  endfunction

  assign in_range = (32'(bus.iData) < 32'(OUT_N));

  // Next scan index: upward wrap, or ping-pong when the direction flag exists.
  always_comb begin
    scan_nxt = '0;
`ifdef SCAN_BIDIR_EN
    dir_nxt = dir_q;
    if (OUT_N == 1) begin
      scan_nxt = '0;
    end else if (!dir_q) begin
      if (idx_q == LAST_IDX) begin
        scan_nxt = idx_q - 1'b1;
        dir_nxt  = 1'b1;
      end else begin
        scan_nxt = idx_q + 1'b1;
      end
    end else begin
      if (idx_q == '0) begin
        scan_nxt = idx_q + 1'b1;
        dir_nxt  = 1'b0;
      end else begin
        scan_nxt = idx_q - 1'b1;
      end
    end
`else
    scan_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`endif
  end

  // Mode decode and next-state/output computation.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    strobe_hi_d = strobe_hi_q;
`ifdef SCAN_BIDIR_EN
    dir_d       = dir_q;
`endif
    if (bus.iEna) begin
      case (bus.iMode)
        2'b00: begin
          state_d     = ST_LATCH;
          cnt_d       = '0;
          strobe_hi_d = 1'b0;
          valid_d     = 1'b1;
          if (in_range) begin
            data_d = onehot(bus.iData);
            idx_d  = bus.iData;
          end else begin
            data_d = '0;
            idx_d  = '0;
            err_d  = 1'b1;
          end
        end
        2'b01: begin
          state_d = ST_STROBE;
          cnt_d   = '0;
          if (state_q == ST_STROBE && strobe_hi_q) begin
            data_d      = '0;
            idx_d       = '0;
            strobe_hi_d = 1'b0;
          end else begin
            strobe_hi_d = 1'b1;
            // An out-of-range pulse leaves oData at zero, so no oValid.
            if (in_range) begin
              data_d  = onehot(bus.iData);
              idx_d   = bus.iData;
              valid_d = 1'b1;
            end else begin
              data_d = '0;
              idx_d  = '0;
              err_d  = 1'b1;
            end
          end
        end
        2'b10: begin
          state_d     = ST_SCAN;
          strobe_hi_d = 1'b0;
          if (state_q != ST_SCAN) begin
            cnt_d   = '0;
            valid_d = 1'b1;
`ifdef SCAN_BIDIR_EN
            dir_d   = 1'b0;
`endif
            if (in_range) begin
              data_d = onehot(bus.iData);
              idx_d  = bus.iData;
            end else begin
              data_d = onehot('0);
              idx_d  = '0;
              err_d  = 1'b1;
            end
          end else if (cnt_q == DIV_TC) begin
            cnt_d   = '0;
            idx_d   = scan_nxt;
            data_d  = onehot(scan_nxt);
            valid_d = 1'b1;
`ifdef SCAN_BIDIR_EN
            dir_d   = dir_nxt;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          data_d      = '0;
          idx_d       = '0;
          cnt_d       = '0;
          strobe_hi_d = 1'b0;
          valid_d     = 1'b1;
        end
      endcase
    end
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      strobe_hi_q <= 1'b0;
`ifdef SCAN_BIDIR_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      strobe_hi_q <= strobe_hi_d;
`ifdef SCAN_BIDIR_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign bus.oData  = data_q;
  assign bus.oIdx   = idx_q;
  assign bus.oValid = valid_q;
  assign bus.oErr   = err_q;

endmodule

// File: doc/decoder_onehot_seq.md
Name: decoder_onehot_seq

Overview:
- Parametrised, registered one-hot decoder; successor to the fixed 5-to-32 combinational decoder.
- Generalised to ADDR_W address bits driving OUT_N outputs.
- Adds four modes: latched decode, single-cycle strobe, auto-scan (walking one-hot with programmable dwell), and clear.
- Drives register-file write enables, LED/segment digit selects and chip selects from one clocked block.

Parameters:
ADDR_W, 5, address width
OUT_N, 32, output count (1 .. 2**ADDR_W); addresses >= OUT_N are out of range
SCAN_DIV, 4, clock cycles per scan step (>= 1)
DIV_W, 16, width of the dwell counter; SCAN_DIV must fit

Ports:
iClk  input  1  clock; all state changes on the rising edge
iRst_n  input  1  asynchronous, active-low reset
iEna  input  1  enable, active high
iMode  input  2  00 LATCH, 01 STROBE, 10 SCAN, 11 CLEAR
iData  input  ADDR_W  address
oData  output  OUT_N  one-hot (or all-zero) decoded output, registered
oIdx  output  ADDR_W  index currently driven (0 when oData is zero)
oValid  output  1  one-cycle pulse whenever oData is updated
oErr  output  1  one-cycle pulse on an out-of-range address

Behaviour:
- Reset (iRst_n=0, asynchronous): oData=0, oIdx=0, oValid=0, oErr=0, FSM=IDLE, dwell counter=0. First update after release is at the first rising edge with iEna=1.
- All outputs are registered. Latency from sampled inputs to outputs is 1 cycle.
- FSM states: IDLE, LATCH, STROBE, SCAN.
  - Each edge with iEna=1 selects the next state from iMode: 00->LATCH, 01->STROBE, 10->SCAN, 11->IDLE.
  - iEna=0: state, oData, oIdx and the dwell counter hold; oValid=0 and oErr=0.
- LATCH (iEna=1, iMode=00), every edge:
  - iData < OUT_N: oData=1<<iData, oIdx=iData.
  - iData >= OUT_N: oData=0, oIdx=0, oErr=1.
  - oValid=1.
- STROBE (iEna=1, iMode=01):
  - Output is decoded as in LATCH for exactly one cycle, then oData returns to 0 on the next edge.
  - Holding iEna high gives alternating pulse/zero cycles.
  - oValid=1 only in the cycle oData is non-zero.
- SCAN:
  - On entry from any other state: index loaded from iData, or 0 with oErr=1 if out of range. oData=1<<index, oValid=1, dwell counter=0.
  - While in SCAN with iEna=1: counter increments each cycle. When it reaches SCAN_DIV-1, it clears and the index advances by 1, wrapping OUT_N-1 -> 0. oValid=1 on each advance.
  - iData is ignored after entry.
  - SCAN_DIV=1: index advances every cycle.
- CLEAR (iMode=11, iEna=1): oData=0, oIdx=0, counter=0, FSM=IDLE, oValid=1.
- Mode change mid-operation takes effect at the next edge. Leaving SCAN discards the dwell count.
- OUT_N not a power of two: wrap occurs at OUT_N-1. Bits above OUT_N never assert.
- oData never has more than one bit set in any cycle.

Optional Feature:
- Macro: SCAN_BIDIR_EN.
- Defined: SCAN runs ping-pong.
  - Direction flag resets to up.
  - At index OUT_N-1 the flag flips to down; at index 0 it flips to up. End indices are not repeated (…30,31,30,…).
  - On SCAN entry the direction is up.
  - OUT_N=1: index stays 0.
- Not defined: SCAN only counts up with wrap, and no direction register is synthesised.

Test Plan:
- Reset with iRst_n=0 mid-SCAN, asynchronous to iClk -> outputs zero immediately. After release with iEna=0 for 3 cycles -> oData stays 0.
- LATCH, iData=5 then iData=31, default params -> oData=0x00000020 then 0x80000000, each 1 cycle after the sample, with oValid pulses. Drop iEna -> 0x80000000 holds.
- OUT_N=20, LATCH with iData=25 -> oData=0, oErr=1 for one cycle; oIdx=0.
- STROBE, iData=3, iEna high for 4 cycles -> oData pattern 0x8, 0, 0x8, 0; oValid high only in the 0x8 cycles.
- SCAN, SCAN_DIV=2, iData=30 -> oIdx 30,30,31,31,0,0,1. Pausing iEna for 3 cycles freezes oIdx and the counter.
- With SCAN_BIDIR_EN, SCAN_DIV=1, OUT_N=4, iData=2 -> oIdx 2,3,2,1,0,1,2. Then iMode=11 -> oData=0, oValid=1.
